bfly_stage_hs: RTL and testbench
================================

// Module: bfly_stage_hs
// PURPOSE
//  Parametrised radix-2 butterfly stage for the FFT datapath. Each accepted beat carries NUM_PAIR
//  complex pairs (a,b) and yields sum a+b and diff a-b in the same output beat. A valid/ready
//  handshake replaces fixed idle/sum/diff phasing. Beats are grouped into frames of FRAME_LEN.
//  Per-frame optional /2 scaling is supported, and a frame-done pulse is issued to the twiddle stage.
// PARAMETERS
//  WIDTH     12  input component width, signed two's complement
//  NUM_PAIR  16  pairs per beat (1..64)
//  FRAME_LEN  4  beats per frame (>=2); beat counter width CW = $clog2(FRAME_LEN)
// PORTS
//  clk         in   1                clock
//  rstn        in   1                asynchronous, active-low reset
//  in_valid    in   1                input beat valid
//  in_ready    out  1                stage can accept a beat
//  scale_en    in   1                /2 scaling for the frame; sampled on a frame's first accepted beat
//  a_re/a_im   in   [NUM_PAIR][WIDTH]   operand a (signed)
//  b_re/b_im   in   [NUM_PAIR][WIDTH]   operand b (signed)
//  out_valid   out  1                output beat valid
//  out_ready   in   1                downstream accepts beat
//  sum_re/im   out  [NUM_PAIR][WIDTH+1] a+b, optionally scaled
//  diff_re/im  out  [NUM_PAIR][WIDTH+1] a-b, optionally scaled
//  out_last    out  1                marks last beat of a frame (qualified by out_valid)
//  frame_done  out  1                1-cycle pulse, cycle after last beat handshakes on output
// BEHAVIOUR
//  - Reset: all outputs 0, in_ready=0 during reset, FSM=IDLE, counters 0, latched scale 0.
//  - Single output register stage; latency 1 cycle from input handshake to out_valid.
//  - in_ready = !out_valid || out_ready, so full throughput is achieved with no bubbles.
//  - Input handshake = in_valid && in_ready; output handshake = out_valid && out_ready.
//  - Output data/out_last hold stable while out_valid && !out_ready.
//  - out_valid clears after an output handshake with no new input handshake.
//  - Arithmetic: sign-extend a and b to WIDTH+1 bits, then add/sub; no overflow is possible.
//  - Scaled result = (full sum, WIDTH+2 bits) >>> 1, then stored in WIDTH+1 bits (arithmetic shift).
//  - FSM states:
//    IDLE -> RUN    on first input handshake: latch scale_en, beat_cnt<=1.
//    RUN  -> DRAIN  on handshake with beat_cnt==FRAME_LEN-1: out_last set on that beat, beat_cnt<=0.
//    DRAIN -> IDLE  on output handshake of the last beat; frame_done pulses the next cycle.
//    DRAIN with a simultaneous new input handshake: accept the beat as the first beat of the next
//      frame (latch scale_en, go to RUN). frame_done still pulses.
//  - beat_cnt wraps FRAME_LEN-1 -> 0; scale_en is ignored mid-frame.
//  - rstn asserted mid-frame: the partial frame is discarded, no frame_done; restart in IDLE.
// CONFIGURATION
//  BFLY_ROUND_EN defined: scaled results use round-half-up, i.e. (x + 1) >>> 1.
//  BFLY_ROUND_EN not defined: scaled results truncate, i.e. x >>> 1 (toward -inf).
//  Unscaled results are identical in both builds.
// STRUCTURE
//  Package fft_pkg:
//    bfly_state_t enum {IDLE, RUN, DRAIN}
//    localparam function clog2_min1 (returns >=1)
//    function bfly_scale(x, en) holding the rounding rule
//  Sub-module bfly_lane: one pair, combinational sum/diff plus scaling; generate NUM_PAIR instances.
//  Top level holds the FSM, beat counter, handshake and output registers.
// TESTING
//  1. Reset, then frame of 4 beats, scale 0, a=(100,-50), b=(27,60) all lanes, out_ready=1
//     -> sum=(127,10), diff=(73,-110), out_last on beat 4, frame_done 1 cycle after.
//  2. Extremes, scale 0: a=2047, b=2047 -> sum=4094. a=-2048, b=2047 -> diff=-4095. No wrap.
//  3. scale 1, a=3, b=0 -> sum=1 without BFLY_ROUND_EN, 2 with it. a=-3, b=0 -> -2 / -1.
//  4. Backpressure: out_ready=0 for 3 cycles on beat 2 -> in_ready=0, output held stable,
//     no beats lost or duplicated.
//  5. Back-to-back frames: continuous valid, scale_en toggled on beat 3
//     -> frame 2 uses the value at its first beat; zero bubbles.
//  6. rstn pulse on beat 2 -> outputs 0 at once; the next frame counts from beat 1; no frame_done.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT butterfly datapath.
// BFLY_ROUND_EN selects round-half-up scaling; otherwise scaling truncates toward -inf.
package fft_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} bfly_state_t;

  // Counter width that stays legal (>=1 bit) for tiny frame lengths.
  function automatic int unsigned clog2_min1(input int unsigned n);
    int unsigned w;
    w = (n <= 2) ? 1 : $clog2(n);
    return w;
  endfunction

  // Operands arrive sign-extended to 64 bits; callers keep the low WIDTH+1 bits.
  function automatic logic signed [63:0] bfly_scale(input logic signed [63:0] x,
                                                    input logic en);
    if (!en) return x;
`ifdef BFLY_ROUND_EN
    return (x + 64'sd1) >>> 1;
`else
    return x >>> 1;
`endif
  endfunction

endpackage

// File: rtl/bfly_lane.sv
// One butterfly lane: combinational a+b and a-b with optional /2 scaling.
// Rounding behaviour follows BFLY_ROUND_EN through fft_pkg::bfly_scale.
module bfly_lane
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = 12
) (
  input  logic signed [WIDTH-1:0] a_re_i,
  input  logic signed [WIDTH-1:0] a_im_i,
  input  logic signed [WIDTH-1:0] b_re_i,
  input  logic signed [WIDTH-1:0] b_im_i,
  input  logic                    scale_i,
  output logic signed [WIDTH:0]   sum_re_o,
  output logic signed [WIDTH:0]   sum_im_o,
  output logic signed [WIDTH:0]   diff_re_o,
  output logic signed [WIDTH:0]   diff_im_o
);

  localparam int unsigned OW = WIDTH + 1;

  // Wide signed arithmetic cannot overflow; the scaled or unscaled result fits in WIDTH+1 bits.
  assign sum_re_o  = OW'(bfly_scale(64'(a_re_i) + 64'(b_re_i), scale_i));
  assign sum_im_o  = OW'(bfly_scale(64'(a_im_i) + 64'(b_im_i), scale_i));
  assign diff_re_o = OW'(bfly_scale(64'(a_re_i) - 64'(b_re_i), scale_i));
  assign diff_im_o = OW'(bfly_scale(64'(a_im_i) - 64'(b_im_i), scale_i));

endmodule

// File: rtl/bfly_stage_hs.sv
// Radix-2 butterfly stage with valid/ready handshake, frame tracking and frame-done pulse.
// Scaling rounding mode is selected by BFLY_ROUND_EN (see fft_pkg).
module bfly_stage_hs
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH     = 12,
  parameter int unsigned NUM_PAIR  = 16,
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  input  logic                               scale_en_i,
  input  logic [NUM_PAIR-1:0][WIDTH-1:0]     a_re_i,
  input  logic [NUM_PAIR-1:0][WIDTH-1:0]     a_im_i,
  input  logic [NUM_PAIR-1:0][WIDTH-1:0]     b_re_i,
  input  logic [NUM_PAIR-1:0][WIDTH-1:0]     b_im_i,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic [NUM_PAIR-1:0][WIDTH:0]       sum_re_o,
  output logic [NUM_PAIR-1:0][WIDTH:0]       sum_im_o,
  output logic [NUM_PAIR-1:0][WIDTH:0]       diff_re_o,
  output logic [NUM_PAIR-1:0][WIDTH:0]       diff_im_o,
  output logic                               out_last_o,
  output logic                               frame_done_o
);

  localparam int unsigned    CW       = clog2_min1(FRAME_LEN);
  localparam logic [CW-1:0]  LastBeat = CW'(FRAME_LEN - 1);

  typedef logic [NUM_PAIR-1:0][WIDTH:0] vec_t;

  bfly_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          scale_q, scale_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic          frame_done_q, frame_done_d;
  vec_t          sum_re_q, sum_im_q, diff_re_q, diff_im_q;
  vec_t          sum_re_w, sum_im_w, diff_re_w, diff_im_w;
  logic          in_hs, out_hs, beat_scale;

  assign in_ready_o = rstn & (~out_valid_q | out_ready_i);
  assign in_hs      = in_valid_i & in_ready_o;
  assign out_hs     = out_valid_q & out_ready_i;
  // The first beat of a frame uses scale_en directly; later beats use the latched value.
  assign beat_scale = (state_q == StRun) ? scale_q : scale_en_i;

  for (genvar p = 0; p < NUM_PAIR; p++) begin : g_lane
    bfly_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .a_re_i    (a_re_i[p]),
      .a_im_i    (a_im_i[p]),
      .b_re_i    (b_re_i[p]),
      .b_im_i    (b_im_i[p]),
      .scale_i   (beat_scale),
      .sum_re_o  (sum_re_w[p]),
      .sum_im_o  (sum_im_w[p]),
      .diff_re_o (diff_re_w[p]),
      .diff_im_o (diff_im_w[p])
    );
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    scale_d      = scale_q;
    out_valid_d  = out_valid_q & ~out_hs;
    out_last_d   = out_last_q;
    frame_done_d = out_hs & out_last_q;
    unique case (state_q)
      StIdle, StDrain: begin
        if (state_q == StDrain && out_hs) state_d = StIdle;
        if (in_hs) begin
          state_d = StRun;
          scale_d = scale_en_i;
          cnt_d   = CW'(1);
        end
      end
      StRun: begin
        if (in_hs) begin
          if (cnt_q == LastBeat) begin
            state_d = StDrain;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (in_hs) begin
      out_valid_d = 1'b1;
      out_last_d  = (state_q == StRun) && (cnt_q == LastBeat);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      scale_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      sum_re_q     <= '0;
      sum_im_q     <= '0;
      diff_re_q    <= '0;
      diff_im_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scale_q      <= scale_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      if (in_hs) begin
        sum_re_q  <= sum_re_w;
        sum_im_q  <= sum_im_w;
        diff_re_q <= diff_re_w;
        diff_im_q <= diff_im_w;
      end
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_last_o   = out_last_q;
  assign frame_done_o = frame_done_q;
  assign sum_re_o     = sum_re_q;
  assign sum_im_o     = sum_im_q;
  assign diff_re_o    = diff_re_q;
  assign diff_im_o    = diff_im_q;

endmodule

// File: tb/tb_bfly_stage_hs.sv
// Randomised self-checking bench for bfly_stage_hs against a frame-level reference model.
// Honours BFLY_ROUND_EN in the model so both builds are checked.
module tb_bfly_stage_hs;

  localparam int WIDTH     = 12;
  localparam int NUM_PAIR  = 16;
  localparam int FRAME_LEN = 4;
  localparam int OW        = WIDTH + 1;

  typedef logic [NUM_PAIR-1:0][OW-1:0] vec_t;
  typedef struct {
    vec_t sre;
    vec_t sim;
    vec_t dre;
    vec_t dim;
    logic last;
  } beat_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic scale_en = 1'b0;
  logic in_ready, out_valid, out_last, frame_done;
  logic [NUM_PAIR-1:0][WIDTH-1:0] a_re = '0, a_im = '0, b_re = '0, b_im = '0;
  vec_t sum_re, sum_im, diff_re, diff_im;

  always #5 clk = ~clk;

  bfly_stage_hs #(
    .WIDTH     (WIDTH),
    .NUM_PAIR  (NUM_PAIR),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .scale_en_i   (scale_en),
    .a_re_i       (a_re),
    .a_im_i       (a_im),
    .b_re_i       (b_re),
    .b_im_i       (b_im),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .sum_re_o     (sum_re),
    .sum_im_o     (sum_im),
    .diff_re_o    (diff_re),
    .diff_im_o    (diff_im),
    .out_last_o   (out_last),
    .frame_done_o (frame_done)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  beat_t exp_q[$];
  int    frame_pos = 0;
  logic  scale_lat = 1'b0;
  logic  fd_exp    = 1'b0;

  // Stimulus knobs
  int unsigned p_valid = 100, p_ready = 100;
  int data_mode  = 0;  // 0 random, 1 fixed operands
  int scale_mode = 0;  // 0 / 1 fixed, 2 random per cycle
  int fa_re = 0, fa_im = 0, fb_re = 0, fb_im = 0;

  function automatic int floor_half(input int x);
    return (x < 0 && (x % 2) != 0) ? (x / 2 - 1) : (x / 2);
  endfunction

  function automatic int ref_scale(input int x, input logic en);
    if (!en) return x;
`ifdef BFLY_ROUND_EN
    return floor_half(x + 1);
`else
    return floor_half(x);
`endif
  endfunction

  task automatic model_accept();
    beat_t bt;
    int ar, ai, br, bi;
    if (frame_pos == 0) scale_lat = scale_en;
    for (int p = 0; p < NUM_PAIR; p++) begin
      ar = int'(signed'(a_re[p]));
      ai = int'(signed'(a_im[p]));
      br = int'(signed'(b_re[p]));
      bi = int'(signed'(b_im[p]));
      bt.sre[p] = OW'(ref_scale(ar + br, scale_lat));
      bt.sim[p] = OW'(ref_scale(ai + bi, scale_lat));
      bt.dre[p] = OW'(ref_scale(ar - br, scale_lat));
      bt.dim[p] = OW'(ref_scale(ai - bi, scale_lat));
    end
    bt.last   = (frame_pos == FRAME_LEN - 1);
    frame_pos = (frame_pos + 1) % FRAME_LEN;
    exp_q.push_back(bt);
  endtask

  task automatic drive();
    in_valid  = ($urandom_range(99) < p_valid);
    out_ready = ($urandom_range(99) < p_ready);
    scale_en  = (scale_mode == 2) ? 1'($urandom) : (scale_mode == 1);
    for (int p = 0; p < NUM_PAIR; p++) begin
      if (data_mode == 1) begin
        a_re[p] = WIDTH'(fa_re);
        a_im[p] = WIDTH'(fa_im);
        b_re[p] = WIDTH'(fb_re);
        b_im[p] = WIDTH'(fb_im);
      end else begin
        a_re[p] = WIDTH'($urandom);
        a_im[p] = WIDTH'($urandom);
        b_re[p] = WIDTH'($urandom);
        b_im[p] = WIDTH'($urandom);
      end
    end
  endtask

  // One clock: check presented outputs, apply new inputs, record the coming handshakes.
  task automatic step();
    beat_t bt;
    @(negedge clk);
    check_eq("frame_done", frame_done, fd_exp);
    check_eq("out_valid", out_valid, exp_q.size() != 0);
    if (out_valid && exp_q.size() != 0) begin
      bt = exp_q[0];
      check_eq("sum_re", sum_re, bt.sre);
      check_eq("sum_im", sum_im, bt.sim);
      check_eq("diff_re", diff_re, bt.dre);
      check_eq("diff_im", diff_im, bt.dim);
      check_eq("out_last", out_last, bt.last);
    end
    drive();
    #1;
    check_eq("in_ready", in_ready, !out_valid || out_ready);
    fd_exp = 1'b0;
    if (out_valid && out_ready && exp_q.size() != 0) begin
      fd_exp = exp_q[0].last;
      void'(exp_q.pop_front());
    end
    if (in_valid && in_ready) model_accept();
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_in_ready"}, in_ready, 1'b0);
    check_eq({tag, "_out_valid"}, out_valid, 1'b0);
    check_eq({tag, "_out_last"}, out_last, 1'b0);
    check_eq({tag, "_frame_done"}, frame_done, 1'b0);
    check_eq({tag, "_data"}, {sum_re, sum_im, diff_re, diff_im}, '0);
  endtask

  task automatic set_fixed(input int ar, input int ai, input int br, input int bi);
    data_mode = 1;
    fa_re = ar;
    fa_im = ai;
    fb_re = br;
    fb_im = bi;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rstn = 1'b1;

    // Basic frame, then extremes, then scaled small values
    set_fixed(100, -50, 27, 60);
    repeat (8) step();
    set_fixed(2047, 2047, 2047, 2047);
    repeat (4) step();
    set_fixed(-2048, -2048, 2047, 2047);
    repeat (4) step();
    scale_mode = 1;
    set_fixed(3, -3, 0, 0);
    repeat (4) step();
    set_fixed(-3, 3, 0, 0);
    repeat (4) step();

    // Backpressure on beat 2
    scale_mode = 0;
    data_mode  = 0;
    repeat (2) step();
    p_ready = 0;
    repeat (3) step();
    p_ready = 100;
    repeat (8) step();

    // Back-to-back frames with scale_en changing every cycle
    scale_mode = 2;
    repeat (16) step();

    // Reset pulse on beat 2 of a frame
    p_valid = 0;
    repeat (3) step();
    p_valid = 100;
    repeat (2) step();
    rstn     = 1'b0;
    in_valid = 1'b0;
    #1;
    check_reset_state("midreset");
    exp_q.delete();
    frame_pos = 0;
    fd_exp    = 1'b0;
    @(negedge clk);
    check_reset_state("held_reset");
    rstn = 1'b1;
    repeat (10) step();

    // Random soak
    p_valid = 70;
    p_ready = 70;
    repeat (400) step();

    // Drain
    p_valid = 0;
    p_ready = 100;
    repeat (4) step();
    check_eq("drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
